// File: rtl/mcp4922_rx.sv
// SPI receiver/decoder for 16-bit MCP4922 DAC command frames, sampled in the clk domain.
// Optional frame/error statistics counters are enabled by defining MCP4922_RX_STATS_EN.
module mcp4922_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_pin,
  input  logic        clk_pin,
  input  logic        data_pin,
  output logic        frame_valid,
  output logic        frame_axis,
  output logic        frame_buffered,
  output logic        frame_gain,
  output logic        frame_shutdown,
  output logic [11:0] frame_value,
  output logic        frame_error,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic        busy,
`ifdef MCP4922_RX_STATS_EN
  output logic [15:0] frame_count,
  output logic [15:0] error_count,
`endif
  output logic        o_dbg_state
);

  // Handshake: frame_valid/frame_error are single-cycle strobes with no back-pressure;
  // the frame_* fields are valid in the frame_valid cycle and hold until the next good frame.

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_cs_hist;
  logic                   r_clk_hist;
  logic [15:0]            r_shift;
  logic [4:0]             r_count;
  logic                   r_end_pending;
  logic                   r_valid;
  logic                   r_error;
  logic [15:0]            r_frame;
  logic [11:0]            r_dac_a;
  logic [11:0]            r_dac_b;
  logic                   w_cs_s;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_sclk_rise;
  logic                   w_start;
  logic                   w_end;
  logic                   w_shift_en;

  // CS and SCLK synchronizers idle high so no spurious edge appears out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cs_sync   <= '1;
      r_clk_sync  <= '1;
      r_data_sync <= '0;
      r_cs_hist   <= 1'b1;
      r_clk_hist  <= 1'b1;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_pin};
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], clk_pin};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_pin};
      r_cs_hist   <= w_cs_s;
      r_clk_hist  <= w_clk_s;
    end
  end

  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s    = r_data_sync[SYNC_STAGES-1];
  assign w_cs_fall   = r_cs_hist & ~w_cs_s;
  assign w_cs_rise   = ~r_cs_hist & w_cs_s;
  assign w_sclk_rise = w_clk_s & ~r_clk_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A CS edge always wins over a coincident SCLK edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_SHIFT;
          w_start     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_end       = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift_en = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decode one cycle after the CS rise; a back-to-back start clears r_shift on the
  // same edge, but the decode reads the pre-clear value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift       <= '0;
      r_count       <= '0;
      r_end_pending <= 1'b0;
      r_valid       <= 1'b0;
      r_error       <= 1'b0;
      r_frame       <= '0;
      r_dac_a       <= '0;
      r_dac_b       <= '0;
    end else begin
      r_end_pending <= w_end;
      r_valid       <= 1'b0;
      r_error       <= 1'b0;
      if (w_start) begin
        r_shift <= '0;
        r_count <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[14:0], w_data_s};
        if (r_count != 5'd17) r_count <= r_count + 5'd1;
      end
      if (r_end_pending) begin
        if (r_count == 5'd16) begin
          r_valid <= 1'b1;
          r_frame <= r_shift;
          if (r_shift[15]) r_dac_b <= r_shift[12] ? r_shift[11:0] : 12'd0;
          else             r_dac_a <= r_shift[12] ? r_shift[11:0] : 12'd0;
        end else begin
          r_error <= 1'b1;
        end
      end
    end
  end

`ifdef MCP4922_RX_STATS_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_error_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_count <= '0;
      r_error_count <= '0;
    end else begin
      if (r_valid) r_frame_count <= r_frame_count + 16'd1;
      if (r_error) r_error_count <= r_error_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
`endif

  assign frame_valid    = r_valid;
  assign frame_error    = r_error;
  assign frame_axis     = r_frame[15];
  assign frame_buffered = r_frame[14];
  assign frame_gain     = r_frame[13];
  assign frame_shutdown = r_frame[12];
  assign frame_value    = r_frame[11:0];
  assign dac_a          = r_dac_a;
  assign dac_b          = r_dac_b;
  assign busy           = ~w_cs_s;
  assign o_dbg_state    = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_mcp4922_rx.sv
// Scoreboard bench for mcp4922_rx: stimulus pushes expected pulses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_mcp4922_rx;
  localparam int W = 41;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs_pin = 1'b1;
  logic        clk_pin = 1'b0;
  logic        data_pin = 1'b0;
  logic        frame_valid, frame_axis, frame_buffered, frame_gain, frame_shutdown;
  logic [11:0] frame_value, dac_a, dac_b;
  logic        frame_error, busy, dbg_state;
`ifdef MCP4922_RX_STATS_EN
  logic [15:0] frame_count, error_count;
`endif

  mcp4922_rx #(.SYNC_STAGES(2)) dut (
`ifdef MCP4922_RX_STATS_EN
    .frame_count(frame_count),
    .error_count(error_count),
`endif
    .clk(clk),
    .reset(reset),
    .cs_pin(cs_pin),
    .clk_pin(clk_pin),
    .data_pin(data_pin),
    .frame_valid(frame_valid),
    .frame_axis(frame_axis),
    .frame_buffered(frame_buffered),
    .frame_gain(frame_gain),
    .frame_shutdown(frame_shutdown),
    .frame_value(frame_value),
    .frame_error(frame_error),
    .dac_a(dac_a),
    .dac_b(dac_b),
    .busy(busy),
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state: {is_valid, frame_word, dac_a, dac_b}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_item;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [15:0]  m_word = 16'h0;
  logic [11:0]  m_a = 12'h0;
  logic [11:0]  m_b = 12'h0;
  int           seen_frames = 0;
  int           seen_errors = 0;
  bit           async_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void expect_end(input logic [15:0] w, input int counted);
    if (counted == 16) begin
      m_word = w;
      if (w[15]) m_b = w[12] ? w[11:0] : 12'h0;
      else       m_a = w[12] ? w[11:0] : 12'h0;
      exp_q.push_back({1'b1, m_word, m_a, m_b});
    end else begin
      exp_q.push_back({1'b0, m_word, m_a, m_b});
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (reset && (frame_valid || frame_error)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b, expected no pulse",
                 frame_valid, frame_error);
      end else begin
        mon_item = exp_q.pop_front();
        check("pulse_kind", 32'({frame_valid, frame_error}), mon_item[40] ? 32'h2 : 32'h1);
        check("frame_fields", 32'({frame_axis, frame_buffered, frame_gain, frame_shutdown,
              frame_value}), 32'(mon_item[39:24]));
        check("dac_a", 32'(dac_a), 32'(mon_item[23:12]));
        check("dac_b", 32'(dac_b), 32'(mon_item[11:0]));
        if (mon_item[40]) seen_frames++;
        else              seen_errors++;
`ifdef MCP4922_RX_STATS_EN
        check("frame_count", 32'(frame_count), 32'(seen_frames));
        check("error_count", 32'(error_count), 32'(seen_errors));
`endif
      end
    end
  end

  // Driver tasks: pins change on negedge (plus jitter in async mode)
  task automatic phase(input int ph);
    repeat (ph) @(negedge clk);
    if (async_mode) #($urandom_range(0, 4));
  endtask

  task automatic cs_low(input int ph);
    cs_pin = 1'b0;
    phase(ph);
  endtask

  task automatic cs_high(input int ph);
    cs_pin = 1'b1;
    phase(ph);
  endtask

  task automatic clock_bits(input logic [15:0] w, input int n, input int ph, input bit last_with_cs);
    for (int i = 0; i < n; i++) begin
      clk_pin  = 1'b0;
      data_pin = (i < 16) ? w[15-i] : 1'b0;
      phase(ph);
      clk_pin = 1'b1;
      if (last_with_cs && i == n - 1) cs_pin = 1'b1;
      phase(ph);
    end
  endtask

  task automatic send_frame(input logic [15:0] w, input int n, input int ph);
    cs_low(ph);
    clock_bits(w, n, ph, 1'b0);
    expect_end(w, (n > 17) ? 17 : n);
    cs_high(ph);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending pulses, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_fields"}, 32'({frame_axis, frame_buffered, frame_gain, frame_shutdown,
          frame_value}), 32'h0);
    check({name, "_dac_a"}, 32'(dac_a), 32'h0);
    check({name, "_dac_b"}, 32'(dac_b), 32'h0);
    check({name, "_pulses"}, 32'({frame_valid, frame_error}), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Stimulus
  initial begin
    logic [15:0] w;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
`ifdef MCP4922_RX_STATS_EN
    check("reset_counts", 32'({frame_count, error_count}), 32'h0);
`endif
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 0x7ABC to DAC A at clk/2
    cs_low(1);
    phase(3);
    check("busy_in_frame", 32'(busy), 32'h1);
    clock_bits(16'h7ABC, 16, 1, 1'b0);
    expect_end(16'h7ABC, 16);
    cs_high(1);
    drain("t1");
    check("t1_dac_a", 32'(dac_a), 32'hABC);
    check("t1_dac_b", 32'(dac_b), 32'h0);
    check("t1_flags", 32'({frame_axis, frame_buffered, frame_gain, frame_shutdown}), 32'h7);
    check("t1_busy_idle", 32'(busy), 32'h0);

    // Back-to-back: 0xF123 to B, then 0x6456 shutting down A
    send_frame(16'hF123, 16, 1);
    send_frame(16'h6456, 16, 1);
    drain("t2");
    check("t2_dac_b", 32'(dac_b), 32'h123);
    check("t2_dac_a", 32'(dac_a), 32'h0);
    check("t2_shutdown", 32'(frame_shutdown), 32'h0);

    // Short and long frames leave everything unchanged
    send_frame(16'h1234, 15, 1);
    send_frame(16'h9999, 17, 1);
    drain("t3");
    check("t3_value", 32'(frame_value), 32'h456);
    check("t3_dacs", 32'({dac_a, dac_b}), 32'h000123);
`ifdef MCP4922_RX_STATS_EN
    check("t3_error_count", 32'(error_count), 32'h2);
`endif

    // Asynchronous source, 3 clk per SCLK phase
    async_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      w = 16'($urandom_range(0, 65535));
      send_frame(w, 16, 3);
      drain("t4");
    end
    async_mode = 1'b0;
    @(negedge clk);

    // Reset mid-frame, released with CS still low
    cs_low(1);
    clock_bits(16'hA5A5, 8, 1, 1'b0);
    reset = 1'b0;
    m_word = 16'h0;
    m_a = 12'h0;
    m_b = 12'h0;
    seen_frames = 0;
    seen_errors = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_all_zero("t5_in_reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    clock_bits(16'h5A00, 8, 1, 1'b0);
    expect_end(16'h5A00, 8);
    cs_high(1);
    drain("t5");
    check_all_zero("t5_after");

    // SCLK rise coincident with CS rise: only 15 edges counted
    cs_low(1);
    clock_bits(16'h3FFF, 16, 1, 1'b1);
    expect_end(16'h3FFF, 15);
    phase(1);
    drain("t6");
    check("t6_dacs", 32'({dac_a, dac_b}), 32'h0);

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
